// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: access-length codes, FSM state encoding and defaults for mem_arbiter.
package mem_arbiter_pkg;
    localparam int          ADDR_WIDTH = 32;
    localparam int          DATA_WIDTH = 32;
    localparam logic [31:0] IO_BASE_DEF = 32'h30000;
    localparam logic [1:0]  LEN_BYTE = 2'd0;
    localparam logic [1:0]  LEN_HALF = 2'd1;
    localparam logic [1:0]  LEN_WORD = 2'd2;

    typedef enum logic [2:0] {IDLE, IF_RD, LSB_RD, LSB_WR, DONE} state_t;

    // Code 3 is illegal and falls through to a word access.
    function automatic logic [2:0] nbytes(input logic [1:0] len);
        return (len == LEN_BYTE) ? 3'd1 : (len == LEN_HALF) ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IF fetches and LSB loads/stores onto the byte-wide RAM/IO port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed LSB-over-IF priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int          ADDR_W  = ADDR_WIDTH,
    parameter int          DATA_W  = DATA_WIDTH,
    parameter logic [31:0] IO_BASE = IO_BASE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              mispredict,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              lsb_req,
    input  logic              lsb_wr,
    input  logic [1:0]        lsb_len,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [DATA_W-1:0] lsb_wdata,
    output logic              lsb_done,
    output logic [DATA_W-1:0] lsb_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);
    state_t            state;
    logic [2:0]        cnt;
    logic [2:0]        len;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] buf_r;
    logic              stall;
    logic [ADDR_W-1:0] nxt_a;
    logic [7:0]        nxt_b;
    logic [1:0]        prev;
    logic [DATA_W-1:0] merged;
    logic              blocked;
    logic              acc_blk;
    logic              grant_lsb;
    logic              grant_if;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_lsb;
`endif

    always_comb begin
        nxt_a     = addr_r + ADDR_W'(cnt);
        nxt_b     = wdata_r[{cnt[1:0], 3'b000} +: 8];
        prev      = cnt[1:0] - 2'd1;
        merged    = buf_r | (DATA_W'(mem_din) << {prev, 3'b000});
        blocked   = io_buffer_full && ((nxt_a & ADDR_W'(IO_BASE)) == ADDR_W'(IO_BASE));
        acc_blk   = io_buffer_full && ((lsb_addr & ADDR_W'(IO_BASE)) == ADDR_W'(IO_BASE));
`ifdef MEM_ARB_ROUND_ROBIN_EN
        grant_lsb = lsb_req && (mispredict ? lsb_wr : (!if_req || !last_lsb));
`else
        grant_lsb = lsb_req && (!mispredict || lsb_wr);
`endif
        grant_if  = if_req && !mispredict && !grant_lsb;
    end

    // A read paused by rdy restarts from byte 0: mem_din no longer tracks cnt after the pause.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            len       <= '0;
            addr_r    <= '0;
            wdata_r   <= '0;
            buf_r     <= '0;
            stall     <= 1'b0;
            if_done   <= 1'b0;
            lsb_done  <= 1'b0;
            if_data   <= '0;
            lsb_rdata <= '0;
            mem_a     <= '0;
            mem_dout  <= '0;
            mem_wr    <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_lsb  <= 1'b0;
`endif
        end else begin
            if_done  <= 1'b0;
            lsb_done <= 1'b0;
            mem_wr   <= 1'b0;
            stall    <= !rdy;
            if (rdy) begin
                case (state)
                    IDLE: begin
                        if (grant_lsb) begin
                            state    <= lsb_wr ? LSB_WR : LSB_RD;
                            addr_r   <= lsb_addr;
                            wdata_r  <= lsb_wdata;
                            len      <= nbytes(lsb_len);
                            buf_r    <= '0;
                            mem_a    <= lsb_addr;
                            mem_dout <= lsb_wdata[7:0];
                            mem_wr   <= lsb_wr && !acc_blk;
                            cnt      <= (lsb_wr && acc_blk) ? 3'd0 : 3'd1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                            last_lsb <= 1'b1;
`endif
                        end else if (grant_if) begin
                            state    <= IF_RD;
                            addr_r   <= if_addr;
                            len      <= 3'd4;
                            buf_r    <= '0;
                            mem_a    <= if_addr;
                            cnt      <= 3'd1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                            last_lsb <= 1'b0;
`endif
                        end
                    end
                    IF_RD, LSB_RD: begin
                        if (mispredict) begin
                            state <= IDLE;
                        end else if (stall) begin
                            mem_a <= addr_r;
                            cnt   <= 3'd1;
                            buf_r <= '0;
                        end else if (cnt == len) begin
                            state <= DONE;
                            if (state == IF_RD) begin
                                if_done <= 1'b1;
                                if_data <= merged;
                            end else begin
                                lsb_done  <= 1'b1;
                                lsb_rdata <= merged;
                            end
                        end else begin
                            buf_r <= merged;
                            mem_a <= nxt_a;
                            cnt   <= cnt + 3'd1;
                        end
                    end
                    LSB_WR: begin
                        if (cnt == len) begin
                            state    <= DONE;
                            lsb_done <= 1'b1;
                        end else if (!blocked) begin
                            mem_a    <= nxt_a;
                            mem_dout <= nxt_b;
                            mem_wr   <= 1'b1;
                            cnt      <= cnt + 3'd1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests for mem_arbiter against a byte RAM model (64 KiB, indexed by mem_a[15:0]).
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        mispredict = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_req = 1'b0;
    logic        lsb_wr = 1'b0;
    logic [1:0]  lsb_len = '0;
    logic [31:0] lsb_addr = '0;
    logic [31:0] lsb_wdata = '0;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    logic [7:0] ram [0:65535];
    int wr_cnt = 0;
    int if_pulses = 0;
    int lsb_pulses = 0;
    int pass = 0;
    int total = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .mispredict(mispredict),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_len(lsb_len), .lsb_addr(lsb_addr),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    assign mem_din = ram[mem_a[15:0]];

    always @(posedge clk) begin
        if (mem_wr) begin
            ram[mem_a[15:0]] <= mem_dout;
            wr_cnt <= wr_cnt + 1;
        end
        if (if_done) if_pulses <= if_pulses + 1;
        if (lsb_done) lsb_pulses <= lsb_pulses + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit want_if, input int limit, output int n);
        n = 0;
        while (((want_if ? if_done : lsb_done) !== 1'b1) && n < limit) begin
            tick();
            n++;
        end
        if ((want_if ? if_done : lsb_done) !== 1'b1) n = -1;
    endtask

    task automatic lsb_set(input bit wr, input logic [1:0] len, input logic [31:0] a, input logic [31:0] d);
        lsb_req = 1'b1;
        lsb_wr = wr;
        lsb_len = len;
        lsb_addr = a;
        lsb_wdata = d;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if ({if_done, lsb_done, if_data, lsb_rdata, mem_a, mem_dout, mem_wr} !== '0)
            $display("FAIL reset_outputs: got %h/%h/%h/%h/%h/%h/%h want all 0",
                     if_done, lsb_done, if_data, lsb_rdata, mem_a, mem_dout, mem_wr);
        else pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_if_fetch;
        if_addr = 32'h100;
        if_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (mem_a !== 32'h100 + 32'(i)) $display("FAIL if_addr_%0d: got %h want %h", i, mem_a, 32'h100 + 32'(i));
            else pass++;
        end
        tick();
        total++;
        if (if_done !== 1'b1 || if_data !== 32'h00000513)
            $display("FAIL if_fetch: got done=%b data=%h want done=1 data=00000513", if_done, if_data);
        else pass++;
        if_req = 1'b0;
        tick();
        total++;
        if (if_done !== 1'b0) $display("FAIL if_done_pulse: got %b want 0", if_done);
        else pass++;
    endtask

    task automatic test_store_word;
        logic [31:0] w;
        w = 32'hDEADBEEF;
        lsb_set(1'b1, LEN_WORD, 32'h200, w);
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (mem_wr !== 1'b1 || mem_a !== 32'h200 + 32'(i) || mem_dout !== w[8*i +: 8])
                $display("FAIL sw_byte_%0d: got wr=%b a=%h d=%h want wr=1 a=%h d=%h",
                         i, mem_wr, mem_a, mem_dout, 32'h200 + 32'(i), w[8*i +: 8]);
            else pass++;
        end
        tick();
        total++;
        if (lsb_done !== 1'b1 || mem_wr !== 1'b0)
            $display("FAIL sw_done: got done=%b wr=%b want done=1 wr=0", lsb_done, mem_wr);
        else pass++;
        lsb_req = 1'b0;
        tick();
        total++;
        if ({ram[16'h203], ram[16'h202], ram[16'h201], ram[16'h200]} !== w)
            $display("FAIL sw_ram: got %h want %h", {ram[16'h203], ram[16'h202], ram[16'h201], ram[16'h200]}, w);
        else pass++;
    endtask

    task automatic test_tie;
        int n;
        logic [31:0] exp_a;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if_addr = 32'h100;
        if_req = 1'b1;
        lsb_set(1'b0, LEN_WORD, 32'h400, 32'h0);
        tick();
        total++;
        if (mem_a !== 32'h400) $display("FAIL tie_first: got a=%h want 00000400", mem_a);
        else pass++;
        wait_done(1'b0, 20, n);
        total++;
        if (n != 4 || lsb_rdata !== 32'h44332211)
            $display("FAIL tie_load: got n=%0d data=%h want n=4 data=44332211", n, lsb_rdata);
        else pass++;
        lsb_req = 1'b0;
        tick();
        tick();
        total++;
        if (mem_a !== 32'h100) $display("FAIL tie_if_next: got a=%h want 00000100", mem_a);
        else pass++;
        wait_done(1'b1, 20, n);
        total++;
        if (n != 4 || if_data !== 32'h00000513)
            $display("FAIL tie_if_data: got n=%0d data=%h want n=4 data=00000513", n, if_data);
        else pass++;
        lsb_req = 1'b1;
        tick();
        tick();
        total++;
        if (mem_a !== 32'h400) $display("FAIL tie_after_if: got a=%h want 00000400", mem_a);
        else pass++;
        wait_done(1'b0, 20, n);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_a = 32'h100;
`else
        exp_a = 32'h400;
`endif
        tick();
        tick();
        total++;
        if (mem_a !== exp_a) $display("FAIL tie_after_lsb: got a=%h want %h", mem_a, exp_a);
        else pass++;
        if_req = 1'b0;
        lsb_req = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_loads;
        int n;
        lsb_set(1'b0, LEN_HALF, 32'h301, 32'h0);
        tick();
        wait_done(1'b0, 20, n);
        total++;
        if (n != 2 || lsb_rdata !== 32'h000080FF)
            $display("FAIL lh_301: got n=%0d data=%h want n=2 data=000080ff", n, lsb_rdata);
        else pass++;
        lsb_req = 1'b0;
        tick();
        lsb_set(1'b0, 2'd3, 32'h400, 32'h0);
        tick();
        wait_done(1'b0, 20, n);
        total++;
        if (n != 4 || lsb_rdata !== 32'h44332211)
            $display("FAIL len3_word: got n=%0d data=%h want n=4 data=44332211", n, lsb_rdata);
        else pass++;
        lsb_req = 1'b0;
        tick();
        ram[16'hFFFF] = 8'h34;
        ram[16'h0000] = 8'h12;
        lsb_set(1'b0, LEN_HALF, 32'hFFFFFFFF, 32'h0);
        tick();
        tick();
        total++;
        if (mem_a !== 32'h0) $display("FAIL addr_wrap: got a=%h want 00000000", mem_a);
        else pass++;
        wait_done(1'b0, 20, n);
        total++;
        if (lsb_rdata !== 32'h00001234) $display("FAIL wrap_data: got %h want 00001234", lsb_rdata);
        else pass++;
        lsb_req = 1'b0;
        tick();
    endtask

    task automatic test_mispredict;
        int n;
        int p0;
        if_addr = 32'h100;
        if_req = 1'b1;
        tick();
        tick();
        mispredict = 1'b1;
        tick();
        mispredict = 1'b0;
        if_req = 1'b0;
        p0 = if_pulses;
        lsb_set(1'b0, LEN_WORD, 32'h400, 32'h0);
        tick();
        total++;
        if (mem_a !== 32'h400) $display("FAIL mp_idle_next: got a=%h want 00000400", mem_a);
        else pass++;
        wait_done(1'b0, 20, n);
        total++;
        if (n != 4 || lsb_rdata !== 32'h44332211 || if_pulses != p0)
            $display("FAIL mp_abort: got n=%0d data=%h if_pulses=%0d want n=4 data=44332211 if_pulses=%0d",
                     n, lsb_rdata, if_pulses, p0);
        else pass++;
        lsb_req = 1'b0;
        tick();
        mispredict = 1'b1;
        if_req = 1'b1;
        lsb_set(1'b1, LEN_BYTE, 32'h500, 32'h5A);
        tick();
        total++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h500 || mem_dout !== 8'h5A)
            $display("FAIL mp_sb_issue: got wr=%b a=%h d=%h want wr=1 a=00000500 d=5a", mem_wr, mem_a, mem_dout);
        else pass++;
        tick();
        total++;
        if (lsb_done !== 1'b1) $display("FAIL mp_sb_done: got %b want 1", lsb_done);
        else pass++;
        lsb_req = 1'b0;
        tick();
        tick();
        total++;
        if (mem_a !== 32'h500 || if_pulses != p0)
            $display("FAIL mp_if_blocked: got a=%h if_pulses=%0d want a=00000500 if_pulses=%0d", mem_a, if_pulses, p0);
        else pass++;
        mispredict = 1'b0;
        if_req = 1'b0;
        tick();
        total++;
        if (ram[16'h500] !== 8'h5A) $display("FAIL mp_sb_ram: got %h want 5a", ram[16'h500]);
        else pass++;
    endtask

    task automatic test_io_backpressure;
        int w0;
        int bad;
        w0 = wr_cnt;
        bad = 0;
        io_buffer_full = 1'b1;
        lsb_set(1'b1, LEN_BYTE, 32'h30000, 32'hA5);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_wr !== 1'b0) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL io_hold: got %0d cycles with mem_wr=1 want 0", bad);
        else pass++;
        io_buffer_full = 1'b0;
        tick();
        total++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h30000 || mem_dout !== 8'hA5)
            $display("FAIL io_release: got wr=%b a=%h d=%h want wr=1 a=00030000 d=a5", mem_wr, mem_a, mem_dout);
        else pass++;
        tick();
        total++;
        if (lsb_done !== 1'b1) $display("FAIL io_done: got %b want 1", lsb_done);
        else pass++;
        lsb_req = 1'b0;
        tick();
        total++;
        if (wr_cnt - w0 != 1) $display("FAIL io_write_count: got %0d want 1", wr_cnt - w0);
        else pass++;
    endtask

    task automatic test_rst_mid;
        int p0;
        lsb_set(1'b1, LEN_WORD, 32'h600, 32'h12345678);
        tick();
        tick();
        total++;
        if (mem_a !== 32'h601) $display("FAIL rst_mid_pre: got a=%h want 00000601", mem_a);
        else pass++;
        rst = 1'b1;
        p0 = lsb_pulses;
        tick();
        total++;
        if ({if_done, lsb_done, if_data, lsb_rdata, mem_a, mem_dout, mem_wr} !== '0)
            $display("FAIL rst_mid_outputs: got a=%h d=%h wr=%b done=%b want all 0", mem_a, mem_dout, mem_wr, lsb_done);
        else pass++;
        rst = 1'b0;
        lsb_req = 1'b0;
        repeat (4) tick();
        total++;
        if (lsb_pulses != p0) $display("FAIL rst_mid_no_done: got %0d pulses want %0d", lsb_pulses, p0);
        else pass++;
    endtask

    task automatic test_rdy_pause;
        int n;
        if_addr = 32'h100;
        if_req = 1'b1;
        tick();
        tick();
        rdy = 1'b0;
        tick();
        tick();
        rdy = 1'b1;
        wait_done(1'b1, 20, n);
        total++;
        if (n != 5 || if_data !== 32'h00000513)
            $display("FAIL rdy_if_restart: got n=%0d data=%h want n=5 data=00000513", n, if_data);
        else pass++;
        if_req = 1'b0;
        tick();
        lsb_set(1'b1, LEN_HALF, 32'h700, 32'hBBAA);
        tick();
        rdy = 1'b0;
        tick();
        total++;
        if (mem_wr !== 1'b0) $display("FAIL rdy_wr_forced: got %b want 0", mem_wr);
        else pass++;
        rdy = 1'b1;
        tick();
        total++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h701 || mem_dout !== 8'hBB)
            $display("FAIL rdy_wr_resume: got wr=%b a=%h d=%h want wr=1 a=00000701 d=bb", mem_wr, mem_a, mem_dout);
        else pass++;
        tick();
        total++;
        if (lsb_done !== 1'b1) $display("FAIL rdy_wr_done: got %b want 1", lsb_done);
        else pass++;
        lsb_req = 1'b0;
        tick();
        total++;
        if ({ram[16'h701], ram[16'h700]} !== 16'hBBAA)
            $display("FAIL rdy_wr_ram: got %h want bbaa", {ram[16'h701], ram[16'h700]});
        else pass++;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h100] = 8'h13;
        ram[16'h101] = 8'h05;
        ram[16'h102] = 8'h00;
        ram[16'h103] = 8'h00;
        ram[16'h301] = 8'hFF;
        ram[16'h302] = 8'h80;
        ram[16'h303] = 8'h77;
        ram[16'h400] = 8'h11;
        ram[16'h401] = 8'h22;
        ram[16'h402] = 8'h33;
        ram[16'h403] = 8'h44;
        test_reset();
        test_if_fetch();
        test_store_word();
        test_tie();
        test_loads();
        test_mispredict();
        test_io_backpressure();
        test_rst_mid();
        test_rdy_pause();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
